// File: rtl/ibex_multdiv_arbiter.sv
// Two-port arbiter in front of one shared multi-cycle multiply/divide unit (IDLE -> BUSY -> RESP).
// Optional MDARB_RR_EN selects round-robin arbitration; without it port 0 has fixed priority.
module ibex_multdiv_arbiter #(
  parameter int CYC_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_ready_o,
  input  logic [3:0]       req_operator_i,
  input  logic [3:0]       req_signed_mode_i,
  input  logic [63:0]      req_op_a_i,
  input  logic [63:0]      req_op_b_i,
  output logic             md_mult_en_o,
  output logic             md_div_en_o,
  output logic [1:0]       md_operator_o,
  output logic [1:0]       md_signed_mode_o,
  output logic [31:0]      md_op_a_o,
  output logic [31:0]      md_op_b_o,
  input  logic [31:0]      md_result_i,
  input  logic             md_valid_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_id_o,
  output logic [31:0]      rsp_result_o,
  output logic [CYC_W-1:0] rsp_cycles_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  localparam logic [CYC_W-1:0] CYC_ONE = CYC_W'(1);
  localparam logic [CYC_W-1:0] CYC_MAX = '1;

  state_t           r_state, w_state_nxt;
  logic             r_gid;
  logic [1:0]       r_operator;
  logic [1:0]       r_signed_mode;
  logic [31:0]      r_op_a;
  logic [31:0]      r_op_b;
  logic             r_rsp_id;
  logic [31:0]      r_result;
  logic [CYC_W-1:0] r_cycles;
  logic [CYC_W-1:0] r_cnt;
  logic [CYC_W-1:0] w_cnt_inc;
  logic             w_grant;
  logic             w_gid;

`ifdef MDARB_RR_EN
  logic r_rr_ptr;
  // The pointer only breaks ties; a lone requester always wins.
  assign w_gid = (req_valid_i == 2'b11) ? r_rr_ptr : ~req_valid_i[0];
`else
  assign w_gid = ~req_valid_i[0];
`endif

  assign w_cnt_inc = (r_cnt == CYC_MAX) ? r_cnt : r_cnt + CYC_ONE;

  always_comb begin
    w_state_nxt  = r_state;
    w_grant      = 1'b0;
    req_ready_o  = 2'b00;
    md_mult_en_o = 1'b0;
    md_div_en_o  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Gated by reset so the accept strobe cannot leak while the state is being forced.
        if (!rst_i && (|req_valid_i)) begin
          w_grant     = 1'b1;
          req_ready_o = w_gid ? 2'b10 : 2'b01;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        md_mult_en_o = ~r_operator[1];
        md_div_en_o  = r_operator[1];
        if (md_valid_i) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_gid         <= 1'b0;
      r_operator    <= 2'b00;
      r_signed_mode <= 2'b00;
      r_op_a        <= 32'd0;
      r_op_b        <= 32'd0;
      r_rsp_id      <= 1'b0;
      r_result      <= 32'd0;
      r_cycles      <= '0;
      r_cnt         <= '0;
`ifdef MDARB_RR_EN
      r_rr_ptr      <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_gid         <= w_gid;
        r_operator    <= w_gid ? req_operator_i[3:2]    : req_operator_i[1:0];
        r_signed_mode <= w_gid ? req_signed_mode_i[3:2] : req_signed_mode_i[1:0];
        r_op_a        <= w_gid ? req_op_a_i[63:32]      : req_op_a_i[31:0];
        r_op_b        <= w_gid ? req_op_b_i[63:32]      : req_op_b_i[31:0];
        r_cnt         <= '0;
`ifdef MDARB_RR_EN
        r_rr_ptr      <= ~r_rr_ptr;
`endif
      end
      if (r_state == S_BUSY) begin
        r_cnt <= w_cnt_inc;
        // The completion cycle itself is part of the reported busy time.
        if (md_valid_i) begin
          r_result <= md_result_i;
          r_cycles <= w_cnt_inc;
          r_rsp_id <= r_gid;
        end
      end
    end
  end

  assign md_operator_o    = r_operator;
  assign md_signed_mode_o = r_signed_mode;
  assign md_op_a_o        = r_op_a;
  assign md_op_b_o        = r_op_b;
  assign rsp_valid_o      = (r_state == S_RESP);
  assign rsp_id_o         = r_rsp_id;
  assign rsp_result_o     = r_result;
  assign rsp_cycles_o     = r_cycles;

endmodule

// File: tb/tb_ibex_multdiv_arbiter.sv
// Bench for ibex_multdiv_arbiter: behavioural slow mul/div unit, vector table, corner sequences, random traffic.
module tb_ibex_multdiv_arbiter;

  localparam int CYC_W = 6;
  localparam int CYC_SAT = (1 << CYC_W) - 1;

  logic             clk_i;
  logic             rst_i;
  logic [1:0]       req_valid_i;
  logic [1:0]       req_ready_o;
  logic [3:0]       req_operator_i;
  logic [3:0]       req_signed_mode_i;
  logic [63:0]      req_op_a_i;
  logic [63:0]      req_op_b_i;
  logic             md_mult_en_o;
  logic             md_div_en_o;
  logic [1:0]       md_operator_o;
  logic [1:0]       md_signed_mode_o;
  logic [31:0]      md_op_a_o;
  logic [31:0]      md_op_b_o;
  logic [31:0]      md_result_i;
  logic             md_valid_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic             rsp_id_o;
  logic [31:0]      rsp_result_o;
  logic [CYC_W-1:0] rsp_cycles_o;

  int   checks = 0;
  int   errors = 0;
  int   lat_override = 0;
  bit   spur = 0;
  logic m_ptr = 1'b0;
  int   u_cnt;
  int   u_lat;

  ibex_multdiv_arbiter #(.CYC_W(CYC_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_operator_i(req_operator_i), .req_signed_mode_i(req_signed_mode_i),
    .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i),
    .md_mult_en_o(md_mult_en_o), .md_div_en_o(md_div_en_o),
    .md_operator_o(md_operator_o), .md_signed_mode_o(md_signed_mode_o),
    .md_op_a_o(md_op_a_o), .md_op_b_o(md_op_b_o),
    .md_result_i(md_result_i), .md_valid_i(md_valid_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_id_o(rsp_id_o), .rsp_result_o(rsp_result_o), .rsp_cycles_o(rsp_cycles_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Arithmetic of the slow unit, straight from the operation definitions.
  function automatic logic [31:0] unit_fn(input logic [1:0] op, input logic [1:0] sm,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = {{32{sm[0] & a[31]}}, a};
    eb = {{32{sm[1] & b[31]}}, b};
    p  = ea * eb;
    case (op)
      2'd0: return p[31:0];
      2'd1: return p[63:32];
      2'd2: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (sm == 2'b11) return $signed(a) / $signed(b);
        return a / b;
      end
      default: begin
        if (b == 32'd0) return a;
        if (sm == 2'b11) return $signed(a) % $signed(b);
        return a % b;
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
    if (lat_override != 0) return lat_override;
    if (!op[1]) return 33;
    if (b == 32'd0) return 2;
    return 37;
  endfunction

  function automatic int model_gid(input logic [1:0] v);
`ifdef MDARB_RR_EN
    if (v == 2'b11) return int'(m_ptr);
`endif
    return v[0] ? 0 : 1;
  endfunction

  always_comb u_lat = exp_lat(md_operator_o, md_op_b_o);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) u_cnt <= 0;
    else if (md_mult_en_o || md_div_en_o) u_cnt <= u_cnt + 1;
    else u_cnt <= 0;
  end

  assign md_valid_i  = spur | ((md_mult_en_o | md_div_en_o) && (u_cnt == u_lat - 1));
  assign md_result_i = spur ? 32'hDEAD_BEEF
                            : unit_fn(md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_txn(input logic [1:0] v, input logic [3:0] op, input logic [3:0] sm,
                        input logic [63:0] a, input logic [63:0] b, input int hold, input bit use_spur,
                        input int exp_id, input logic [31:0] exp_res, input int exp_cyc);
    logic [1:0] gop;
    int lat, en_cnt, guard;
    gop = op[exp_id*2 +: 2];
    lat = exp_lat(gop, b[exp_id*32 +: 32]);
    @(negedge clk_i);
    req_valid_i = v; req_operator_i = op; req_signed_mode_i = sm;
    req_op_a_i = a; req_op_b_i = b;
    #1;
    chk("grant_ready", req_ready_o, (exp_id == 1) ? 2'b10 : 2'b01);
    @(posedge clk_i);
    #1;
    m_ptr = ~m_ptr;
    req_valid_i = 2'b00;
    req_operator_i = 4'($urandom); req_signed_mode_i = 4'($urandom);
    req_op_a_i = {$urandom, $urandom}; req_op_b_i = {$urandom, $urandom};
    @(negedge clk_i);
    chk("md_ops", {md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o},
        {gop, sm[exp_id*2 +: 2], a[exp_id*32 +: 32], b[exp_id*32 +: 32]});
    chk("md_en_kind", {md_mult_en_o, md_div_en_o}, {~gop[1], gop[1]});
    en_cnt = 0;
    guard  = 0;
    while (!rsp_valid_o && guard < 300) begin
      if (md_mult_en_o || md_div_en_o) en_cnt++;
      if (req_ready_o != 2'b00) begin
        errors++;
        $display("FAIL busy_ready: got %0b expected 00", req_ready_o);
      end
      guard++;
      @(negedge clk_i);
    end
    chk("rsp_timeout", guard < 300, 1'b1);
    chk("en_cycles", en_cnt, lat);
    chk("rsp_id", rsp_id_o, exp_id);
    chk("rsp_result", rsp_result_o, exp_res);
    chk("rsp_cycles", rsp_cycles_o, exp_cyc);
    chk("resp_en_off", {md_mult_en_o, md_div_en_o}, 2'b00);
    for (int h = 0; h < hold; h++) begin
      spur = use_spur;
      if (use_spur) req_valid_i = 2'b11;
      #1;
      chk("hold", {rsp_valid_o, req_ready_o, md_mult_en_o, md_div_en_o, rsp_id_o, rsp_result_o, rsp_cycles_o},
          {1'b1, 2'b00, 2'b00, 1'(exp_id), exp_res, CYC_W'(exp_cyc)});
      @(negedge clk_i);
    end
    spur = 0;
    req_valid_i = 2'b00;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    #1;
    chk("after_accept", {rsp_valid_o, rsp_result_o}, {1'b0, exp_res});
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [3:0]  op;
    logic [3:0]  sm;
    logic [63:0] a;
    logic [63:0] b;
    int          hold;
    bit          spur;
    int          lat_ov;
    int          exp_id;
    logic [31:0] exp_res;
    int          exp_cyc;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [1:0]  v, gop, gsm;
    logic [3:0]  op, sm;
    logic [63:0] a, b;
    logic [31:0] bw;
    int gid, ecyc, ngrant, guard;
    int grants[4];

    tbl[0] = '{2'b01, 4'b0000, 4'b0000, 64'd7, 64'd6, 0, 0, 0, 0, 32'd42, 33};
    tbl[1] = '{2'b10, 4'b1000, 4'b1100, {32'hFFFF_FFEC, 32'd0}, {32'd3, 32'd0}, 0, 0, 0, 1, 32'hFFFF_FFFA, 37};
    tbl[2] = '{2'b01, 4'b0010, 4'b0000, 64'd100, 64'd0, 0, 0, 0, 0, 32'hFFFF_FFFF, 2};
    tbl[3] = '{2'b10, 4'b1100, 4'b0000, {32'd17, 32'd0}, {32'd5, 32'd0}, 0, 0, 0, 1, 32'd2, 37};
    tbl[4] = '{2'b01, 4'b0001, 4'b0011, 64'hFFFF_FFFE, 64'd3, 0, 0, 0, 0, 32'hFFFF_FFFF, 33};
    tbl[5] = '{2'b01, 4'b0001, 4'b0000, 64'h8000_0000, 64'd4, 0, 0, 0, 0, 32'd2, 33};
    tbl[6] = '{2'b10, 4'b1100, 4'b1100, {32'hFFFF_FFF7, 32'd0}, 64'd0, 0, 0, 0, 1, 32'hFFFF_FFF7, 2};
    tbl[7] = '{2'b01, 4'b0000, 4'b0000, 64'd3, 64'd5, 0, 0, 70, 0, 32'd15, CYC_SAT};
    tbl[8] = '{2'b10, 4'b0000, 4'b0000, {32'd1000, 32'd0}, {32'd1000, 32'd0}, 10, 1, 0, 1, 32'd1000000, 33};

    rst_i = 1'b1;
    req_valid_i = 2'b11; req_operator_i = 4'b0; req_signed_mode_i = 4'b0;
    req_op_a_i = 64'd5; req_op_b_i = 64'd9; rsp_ready_i = 1'b0;
    #2;
    chk("reset_state", {req_ready_o, md_mult_en_o, md_div_en_o, rsp_valid_o, rsp_id_o, rsp_result_o, rsp_cycles_o},
        {2'b00, 2'b00, 1'b0, 1'b0, 32'd0, CYC_W'(0)});
    chk("reset_md_ops", {md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o}, 68'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    req_valid_i = 2'b00;
    rst_i = 1'b0;

    for (int i = 0; i < 9; i++) begin
      lat_override = tbl[i].lat_ov;
      do_txn(tbl[i].v, tbl[i].op, tbl[i].sm, tbl[i].a, tbl[i].b, tbl[i].hold, tbl[i].spur,
             tbl[i].exp_id, tbl[i].exp_res, tbl[i].exp_cyc);
    end
    lat_override = 0;

    // Both ports requesting continuously with the response drained every cycle.
    lat_override = 3;
    @(negedge clk_i);
    req_valid_i = 2'b11; req_operator_i = 4'b0; req_signed_mode_i = 4'b0;
    req_op_a_i = {32'd2, 32'd3}; req_op_b_i = {32'd4, 32'd5};
    rsp_ready_i = 1'b1;
    ngrant = 0;
    guard = 0;
    while (ngrant < 4 && guard < 200) begin
      #1;
      if (req_ready_o != 2'b00) begin
        grants[ngrant] = req_ready_o[1] ? 1 : 0;
        chk("cont_grant", grants[ngrant], model_gid(2'b11));
        m_ptr = ~m_ptr;
        ngrant++;
      end
      guard++;
      @(negedge clk_i);
    end
    chk("cont_timeout", ngrant, 4);
    req_valid_i = 2'b00;
    repeat (8) @(negedge clk_i);
    rsp_ready_i = 1'b0;
    lat_override = 0;
    chk("cont_idle", {rsp_valid_o, md_mult_en_o, md_div_en_o}, 3'b000);

    // Reset in the middle of a multiply discards it.
    @(negedge clk_i);
    req_valid_i = 2'b01; req_operator_i = 4'b0; req_op_a_i = 64'd11; req_op_b_i = 64'd13;
    @(posedge clk_i);
    #1;
    req_valid_i = 2'b00;
    repeat (15) @(negedge clk_i);
    chk("pre_reset_busy", md_mult_en_o, 1'b1);
    rst_i = 1'b1;
    req_valid_i = 2'b01;
    #1;
    chk("midreset", {md_mult_en_o, md_div_en_o, rsp_valid_o, req_ready_o, md_op_a_o, rsp_result_o},
        {3'b000, 2'b00, 32'd0, 32'd0});
    @(negedge clk_i);
    rst_i = 1'b0;
    req_valid_i = 2'b00;
    m_ptr = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("no_stale_rsp", {rsp_valid_o, md_mult_en_o}, 2'b00);
    do_txn(2'b01, 4'b0000, 4'b0000, 64'd11, 64'd13, 0, 0, 0, 32'd143, 33);

    for (int i = 0; i < 20; i++) begin
      v  = 2'($urandom_range(1, 3));
      op = 4'($urandom);
      sm = 4'($urandom);
      a  = {$urandom, $urandom};
      for (int p = 0; p < 2; p++) begin
        case ($urandom_range(0, 3))
          0:       bw = 32'd0;
          1:       bw = 32'($urandom_range(2, 50));
          2:       bw = -32'($urandom_range(2, 50));
          default: bw = $urandom;
        endcase
        if (bw == 32'hFFFF_FFFF) bw = 32'd7;
        b[p*32 +: 32] = bw;
      end
      lat_override = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0;
      gid = model_gid(v);
      gop = op[gid*2 +: 2];
      gsm = sm[gid*2 +: 2];
      ecyc = exp_lat(gop, b[gid*32 +: 32]);
      if (ecyc > CYC_SAT) ecyc = CYC_SAT;
      do_txn(v, op, sm, a, b, int'($urandom_range(0, 3)), 0, gid,
             unit_fn(gop, gsm, a[gid*32 +: 32], b[gid*32 +: 32]), ecyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
